// File: rtl/plic_target_arbiter.sv
// Purpose: PLIC gateways (IDLE/PENDING/INSERVICE per source) plus per-target priority arbiter and claim/complete.
// Latency: trigger at cycle n -> PENDING at n+1 -> irq_o/irq_id_o registered at n+2; claim_id_o one cycle after claim_i.
// Backpressure: none; triggers seen while PENDING/INSERVICE are dropped, invalid claims return 0, invalid completes are ignored.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   irq_sources_i, le_i  raw interrupt lines and per-source edge(1)/level(0) select
//   prio_i, ie_i         per-source priority (flat), per-target enable matrix
//   threshold_i          per-target priority threshold
//   claim_i, complete_i  one-cycle claim / complete pulses per target
//   complete_id_i        ID being completed per target, sampled with complete_i
//   irq_o, irq_id_o      registered interrupt request and winning ID per target (0 = none)
//   claim_id_o           ID handed out by the last claim per target, held until the next claim
module plic_target_arbiter #(
    parameter int unsigned NumSources  = 30,
    parameter int unsigned NumTargets  = 2,
    parameter int unsigned MaxPriority = 7,
    localparam int unsigned PrioW = $clog2(MaxPriority + 1),
    localparam int unsigned SrcW  = $clog2(NumSources + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumSources-1:0]          irq_sources_i,
    input  logic [NumSources-1:0]          le_i,
    input  logic [NumSources*PrioW-1:0]    prio_i,
    input  logic [NumTargets*NumSources-1:0] ie_i,
    input  logic [NumTargets*PrioW-1:0]    threshold_i,
    input  logic [NumTargets-1:0]          claim_i,
    input  logic [NumTargets-1:0]          complete_i,
    input  logic [NumTargets*SrcW-1:0]     complete_id_i,
    output logic [NumTargets-1:0]          irq_o,
    output logic [NumTargets*SrcW-1:0]     irq_id_o,
    output logic [NumTargets*SrcW-1:0]     claim_id_o
);

    typedef enum logic [1:0] {
        GW_IDLE      = 2'd0,
        GW_PENDING   = 2'd1,
        GW_INSERVICE = 2'd2
    } gw_state_e;

    gw_state_e state_q [NumSources];
    gw_state_e state_d [NumSources];
    logic [NumSources-1:0] prev_q;
    logic [NumSources-1:0] trig;
    logic [NumSources-1:0] claimed;
    logic [NumSources-1:0] done;

    logic [NumTargets-1:0]            irq_q;
    logic [NumTargets-1:0][SrcW-1:0]  irq_id_q;
    logic [NumTargets-1:0][SrcW-1:0]  claim_id_q;
    logic [NumTargets-1:0][SrcW-1:0]  claim_id_d;
    logic [NumTargets-1:0][SrcW-1:0]  arb_id;
    logic [NumTargets-1:0][PrioW-1:0] arb_prio;

    // Edge sources fire on a 0->1 transition of the line, level sources whenever the line is high.
    assign trig = (le_i & irq_sources_i & ~prev_q) | (~le_i & irq_sources_i);

    // Claims resolve against the ID each target is currently being shown. Targets are
    // scanned in ascending order so the lower index wins when two claim the same source.
    always_comb begin
        claimed    = '0;
        claim_id_d = claim_id_q;
        for (int t = 0; t < int'(NumTargets); t++) begin
            if (claim_i[t]) begin
                claim_id_d[t] = '0;
                for (int i = 0; i < int'(NumSources); i++) begin
                    if (irq_id_q[t] == SrcW'(i + 1) && state_q[i] == GW_PENDING && !claimed[i]) begin
                        claimed[i]    = 1'b1;
                        claim_id_d[t] = SrcW'(i + 1);
                    end
                end
            end
        end
    end

    // A complete is accepted from any target; only IDs naming an in-service source match,
    // so 0 and out-of-range IDs fall through naturally.
    always_comb begin
        done = '0;
        for (int i = 0; i < int'(NumSources); i++) begin
            for (int t = 0; t < int'(NumTargets); t++) begin
                if (complete_i[t] && complete_id_i[t*SrcW +: SrcW] == SrcW'(i + 1)
                    && state_q[i] == GW_INSERVICE) begin
                    done[i] = 1'b1;
                end
            end
        end
    end

    // Gateway next state. Completion returns to IDLE only; a still-high level line
    // re-pends on the following cycle.
    always_comb begin
        for (int i = 0; i < int'(NumSources); i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                GW_IDLE:      if (trig[i])    state_d[i] = GW_PENDING;
                GW_PENDING:   if (claimed[i]) state_d[i] = GW_INSERVICE;
                GW_INSERVICE: if (done[i])    state_d[i] = GW_IDLE;
                default:                      state_d[i] = GW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumSources); i++) begin
                state_q[i] <= GW_IDLE;
            end
            prev_q <= '0;
        end else begin
            for (int i = 0; i < int'(NumSources); i++) begin
                state_q[i] <= state_d[i];
            end
            prev_q <= irq_sources_i;
        end
    end

    // Arbitration over registered pending state. Sources claimed this cycle are masked so
    // irq_id_o stops showing them on the very next cycle. Strict '>' while scanning upward
    // keeps the lowest ID on ties; prio > threshold means priority 0 can never win.
    always_comb begin
        arb_id   = '0;
        arb_prio = '0;
        for (int t = 0; t < int'(NumTargets); t++) begin
            for (int i = 0; i < int'(NumSources); i++) begin
                if (state_q[i] == GW_PENDING && !claimed[i] && ie_i[t*NumSources + i]
                    && prio_i[i*PrioW +: PrioW] > threshold_i[t*PrioW +: PrioW]
                    && prio_i[i*PrioW +: PrioW] > arb_prio[t]) begin
                    arb_prio[t] = prio_i[i*PrioW +: PrioW];
                    arb_id[t]   = SrcW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q      <= '0;
            irq_id_q   <= '0;
            claim_id_q <= '0;
        end else begin
            irq_id_q   <= arb_id;
            claim_id_q <= claim_id_d;
            for (int t = 0; t < int'(NumTargets); t++) begin
                irq_q[t] <= (arb_id[t] != '0);
            end
        end
    end

    assign irq_o      = irq_q;
    assign irq_id_o   = irq_id_q;
    assign claim_id_o = claim_id_q;

endmodule

// File: tb/tb_plic_target_arbiter.sv
// Purpose: directed test-plan scenarios plus randomized traffic, each cycle compared against a behavioural model.
// Latency: model tracks per-source gateway state as integers and recomputes winners each edge.
// Backpressure: n/a (bench).
module tb_plic_target_arbiter;

    localparam int NS = 30;
    localparam int NT = 2;
    localparam int PW = 3;
    localparam int SW = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NS-1:0]      irq_src;
    logic [NS-1:0]      le;
    logic [NS*PW-1:0]   prio;
    logic [NT*NS-1:0]   ie;
    logic [NT*PW-1:0]   thr;
    logic [NT-1:0]      claim;
    logic [NT-1:0]      complete;
    logic [NT*SW-1:0]   cid;
    logic [NT-1:0]      irq;
    logic [NT*SW-1:0]   irq_id;
    logic [NT*SW-1:0]   claim_id;

    plic_target_arbiter dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .irq_sources_i (irq_src),
        .le_i          (le),
        .prio_i        (prio),
        .ie_i          (ie),
        .threshold_i   (thr),
        .claim_i       (claim),
        .complete_i    (complete),
        .complete_id_i (cid),
        .irq_o         (irq),
        .irq_id_o      (irq_id),
        .claim_id_o    (claim_id)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 = idle, 1 = pending, 2 = in service.
    int gw      [NS];
    int prev_m  [NS];
    int m_id    [NT];
    int m_claim [NT];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int prio_of(input int i);
        return int'(prio[i*PW +: PW]);
    endfunction

    function automatic int thr_of(input int t);
        return int'(thr[t*PW +: PW]);
    endfunction

    function automatic int dut_id(input int t);
        return int'(irq_id[t*SW +: SW]);
    endfunction

    function automatic int dut_claim(input int t);
        return int'(claim_id[t*SW +: SW]);
    endfunction

    task automatic set_prio(input int i, input int p);
        prio[i*PW +: PW] = PW'(p);
    endtask

    task automatic set_thr(input int t, input int p);
        thr[t*PW +: PW] = PW'(p);
    endtask

    task automatic set_cid(input int t, input int id);
        cid[t*SW +: SW] = SW'(id);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            gw[i]     = 0;
            prev_m[i] = 0;
        end
        for (int t = 0; t < NT; t++) begin
            m_id[t]    = 0;
            m_claim[t] = 0;
        end
    endtask

    task automatic model_step();
        bit taken [NS];
        bit fin   [NS];
        int new_claim [NT];
        int win [NT];
        int best_p;
        int id;
        bit trg;
        for (int i = 0; i < NS; i++) begin
            taken[i] = 1'b0;
            fin[i]   = 1'b0;
        end
        // Claims: each target takes the ID it currently sees if still pending and not taken by a lower target.
        for (int t = 0; t < NT; t++) begin
            new_claim[t] = m_claim[t];
            if (claim[t]) begin
                id = m_id[t];
                new_claim[t] = 0;
                if (id > 0 && gw[id-1] == 1 && !taken[id-1]) begin
                    taken[id-1]  = 1'b1;
                    new_claim[t] = id;
                end
            end
        end
        // Winner: highest priority above threshold among enabled pending, unclaimed sources; lowest ID on ties.
        for (int t = 0; t < NT; t++) begin
            win[t] = 0;
            best_p = -1;
            for (int i = 0; i < NS; i++) begin
                if (gw[i] == 1 && !taken[i] && ie[t*NS + i] && prio_of(i) > thr_of(t)
                    && prio_of(i) > best_p) begin
                    best_p = prio_of(i);
                    win[t] = i + 1;
                end
            end
        end
        for (int t = 0; t < NT; t++) begin
            if (complete[t]) begin
                id = int'(cid[t*SW +: SW]);
                if (id >= 1 && id <= NS && gw[id-1] == 2) fin[id-1] = 1'b1;
            end
        end
        for (int i = 0; i < NS; i++) begin
            trg = le[i] ? (irq_src[i] && prev_m[i] == 0) : irq_src[i];
            if (gw[i] == 0 && trg)           gw[i] = 1;
            else if (gw[i] == 1 && taken[i]) gw[i] = 2;
            else if (gw[i] == 2 && fin[i])   gw[i] = 0;
            prev_m[i] = int'(irq_src[i]);
        end
        for (int t = 0; t < NT; t++) begin
            m_id[t]    = win[t];
            m_claim[t] = new_claim[t];
        end
    endtask

    task automatic compare_all();
        for (int t = 0; t < NT; t++) begin
            chk($sformatf("irq_t%0d", t), int'(irq[t]), (m_id[t] != 0) ? 1 : 0);
            chk($sformatf("irq_id_t%0d", t), dut_id(t), m_id[t]);
            chk($sformatf("claim_id_t%0d", t), dut_claim(t), m_claim[t]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_irq", int'(irq), 0);
        chk("rst_irq_id", int'(irq_id), 0);
        chk("rst_claim_id", int'(claim_id), 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_inputs();
        irq_src  = '0;
        le       = '0;
        prio     = '0;
        ie       = '0;
        thr      = '0;
        claim    = '0;
        complete = '0;
        cid      = '0;
    endtask

    initial begin
        int id;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        do_reset();

        // 1: level ID 5, claim, complete with line still high -> re-pends.
        set_prio(4, 3);
        ie[4] = 1'b1;
        irq_src[4] = 1'b1;
        cycle();
        cycle();
        chk("t1_irq", int'(irq[0]), 1);
        chk("t1_id", dut_id(0), 5);
        claim[0] = 1'b1;
        cycle();
        claim[0] = 1'b0;
        chk("t1_claim", dut_claim(0), 5);
        chk("t1_drop", int'(irq[0]), 0);
        complete[0] = 1'b1;
        set_cid(0, 5);
        cycle();
        complete = '0;
        cycle();
        chk("t1_not_yet", int'(irq[0]), 0);
        cycle();
        chk("t1_rearm", int'(irq[0]), 1);

        // 2: threshold filtering and tie-break.
        clear_inputs();
        do_reset();
        set_prio(2, 2);
        set_prio(6, 5);
        ie[NS + 2] = 1'b1;
        ie[NS + 6] = 1'b1;
        set_thr(1, 4);
        irq_src[2] = 1'b1;
        irq_src[6] = 1'b1;
        cycle();
        cycle();
        chk("t2_win7", dut_id(1), 7);
        set_thr(1, 5);
        cycle();
        chk("t2_thr", dut_id(1), 0);
        set_prio(2, 5);
        set_thr(1, 0);
        cycle();
        chk("t2_tie", dut_id(1), 3);

        // 3: edge ID 10, two pulses -> one claim.
        clear_inputs();
        do_reset();
        le[9] = 1'b1;
        set_prio(9, 1);
        ie[9] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            irq_src[9] = 1'b1;
            cycle();
            irq_src[9] = 1'b0;
            cycle();
        end
        chk("t3_id", dut_id(0), 10);
        claim[0] = 1'b1;
        cycle();
        chk("t3_claim1", dut_claim(0), 10);
        cycle();
        claim[0] = 1'b0;
        chk("t3_claim2", dut_claim(0), 0);
        complete[0] = 1'b1;
        set_cid(0, 10);
        cycle();
        complete = '0;
        cycle();
        chk("t3_idle", int'(irq[0]), 0);
        irq_src[9] = 1'b1;
        cycle();
        irq_src[9] = 1'b0;
        cycle();
        chk("t3_repend", dut_id(0), 10);

        // 4: both targets claim ID 2 in the same cycle.
        clear_inputs();
        do_reset();
        set_prio(1, 1);
        ie[1] = 1'b1;
        ie[NS + 1] = 1'b1;
        irq_src[1] = 1'b1;
        cycle();
        cycle();
        chk("t4_id1", dut_id(1), 2);
        claim = 2'b11;
        cycle();
        claim = '0;
        chk("t4_claim0", dut_claim(0), 2);
        chk("t4_claim1", dut_claim(1), 0);
        cycle();
        chk("t4_irq0", int'(irq[0]), 0);
        chk("t4_irq1", int'(irq[1]), 0);

        // 5: invalid completes ignored; complete of a pending ID ignored.
        complete[0] = 1'b1;
        set_cid(0, 0);
        cycle();
        complete[0] = 1'b0;
        complete[1] = 1'b1;
        set_cid(1, 31);
        cycle();
        complete = '0;
        cycle();
        cycle();
        chk("t5_still_inservice", int'(irq[0]), 0);
        set_prio(2, 2);
        ie[2] = 1'b1;
        irq_src[2] = 1'b1;
        cycle();
        cycle();
        chk("t5_id3", dut_id(0), 3);
        complete[0] = 1'b1;
        set_cid(0, 3);
        cycle();
        complete = '0;
        chk("t5_pending_kept", dut_id(0), 3);
        claim[0] = 1'b1;
        cycle();
        claim[0] = 1'b0;
        chk("t5_claim3", dut_claim(0), 3);

        // 6: reset mid-operation with IDs 2 and 3 in service and lines high.
        do_reset();
        cycle();
        chk("t6_wait", int'(irq[0]), 0);
        cycle();
        chk("t6_irq", int'(irq[0]), 1);
        chk("t6_id", dut_id(0), 3);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(7) == 0) irq_src[i] = ~irq_src[i];
            end
            if ($urandom_range(49) == 0) begin
                for (int i = 0; i < NS; i++) begin
                    le[i] = 1'($urandom_range(1));
                    set_prio(i, $urandom_range(7));
                end
                for (int k = 0; k < NT*NS; k++) ie[k] = 1'($urandom_range(1));
                for (int t = 0; t < NT; t++) set_thr(t, $urandom_range(4));
            end
            for (int t = 0; t < NT; t++) begin
                claim[t]    = ($urandom_range(3) == 0);
                complete[t] = ($urandom_range(3) == 0);
                if ($urandom_range(1) == 1) begin
                    id = $urandom_range(31);
                end else begin
                    id = 0;
                    for (int k = 0; k < NS; k++) begin
                        if (gw[k] == 2 && $urandom_range(2) == 0) id = k + 1;
                    end
                end
                set_cid(t, id);
            end
            if ($urandom_range(499) == 0) do_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
